// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared constants for the multiply/divide unit: MDOP operation codes,
//   the FSM state encoding and small op-classification helpers.
package mul_div_unit_pkg;

   localparam int MDOP_WIDTH = 3;

   localparam logic [MDOP_WIDTH-1:0] MDOP_NONE  = 3'd0;
   localparam logic [MDOP_WIDTH-1:0] MDOP_MULT  = 3'd1;
   localparam logic [MDOP_WIDTH-1:0] MDOP_MULTU = 3'd2;
   localparam logic [MDOP_WIDTH-1:0] MDOP_DIV   = 3'd3;
   localparam logic [MDOP_WIDTH-1:0] MDOP_DIVU  = 3'd4;
   localparam logic [MDOP_WIDTH-1:0] MDOP_MTHI  = 3'd5;
   localparam logic [MDOP_WIDTH-1:0] MDOP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_CALC = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

   // Ops that run through the multi-cycle datapath
   function automatic logic is_md_op(input logic [MDOP_WIDTH-1:0] op);
      case (op)
         MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

   function automatic logic is_div_op(input logic [MDOP_WIDTH-1:0] op);
      case (op)
         MDOP_DIV, MDOP_DIVU: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

   function automatic logic is_signed_op(input logic [MDOP_WIDTH-1:0] op);
      case (op)
         MDOP_MULT, MDOP_DIV: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mul_div_unit_md_step.sv
// md_step
//   Combinational add/subtract step shared by the multiplier (add) and the
//   restoring divider (trial subtract).
//   Ports: x, y   - W-bit operands
//          sub    - 1 selects x - y, 0 selects x + y
//          res    - W-bit result (carry/borrow bit dropped)
//          borrow - set when sub=1 and x < y; 0 when adding
module md_step #(
   parameter int W = 33
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         sub,
   output logic [W-1:0] res,
   output logic         borrow
);

   logic [W-1:0] y_s;
   logic [W:0]   sum_s;

   // Two's-complement add; subtraction as x + ~y + 1, borrow = no carry out
   always_comb begin
      if (sub) begin
         y_s = ~y;
      end else begin
         y_s = y;
      end
      sum_s = {1'b0, x} + {1'b0, y_s} + {{W{1'b0}}, sub};
      res   = sum_s[W-1:0];
      if (sub) begin
         borrow = ~sum_s[W];
      end else begin
         borrow = 1'b0;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit owning HI/LO. One op is accepted per
//   start pulse in IDLE; mult/div take PREP + 32 CALC + FIX cycles with
//   constant latency, mthi/mtlo write HI/LO at the accepting edge.
//   Ports: clk, rst_n (async, active-low)
//          start, op, a, b - operation request
//          flush           - abort in-flight op, blocks IDLE accepts
//          busy, done      - in progress / one-cycle completion pulse
//          div_by_zero     - last div/divu had b == 0
//          hi, lo          - architectural HI/LO registers
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int DP_WIDTH = 32,
   parameter int MD_ITERS = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [MDOP_WIDTH-1:0] op,
   input  logic [DP_WIDTH-1:0]   a,
   input  logic [DP_WIDTH-1:0]   b,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero,
   output logic [DP_WIDTH-1:0]   hi,
   output logic [DP_WIDTH-1:0]   lo
);

   localparam int W  = DP_WIDTH;
   localparam int CW = $clog2(MD_ITERS);
   localparam logic [CW-1:0] LAST_CNT = CW'(MD_ITERS - 1);

   md_state_e             state_r, state_nxt_s;
   logic [MDOP_WIDTH-1:0] op_r;
   logic [W-1:0]          a_r, b_r, opnd_r;
   logic [2*W-1:0]        acc_r, acc_step_s;
   logic [CW-1:0]         count_r;
   logic                  neg_q_r, neg_r_r;
   logic                  busy_r, done_r, dbz_r;
   logic [W-1:0]          hi_r, lo_r;

   logic                  div_op_s, signed_s;
   logic [W-1:0]          mag_a_s, mag_b_s;
   logic [W:0]            step_x_s, step_y_s, step_res_s;
   logic                  step_borrow_s;
   logic [2*W-1:0]        prod_s;
   logic [W-1:0]          quot_s, rem_s, fix_hi_s, fix_lo_s;

   assign div_op_s = is_div_op(op_r);
   assign signed_s = is_signed_op(op_r);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; flush forces IDLE from any state
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start && is_md_op(op)) begin
                  state_nxt_s = ST_PREP;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_PREP: state_nxt_s = ST_CALC;
            ST_CALC: begin
               if (count_r == LAST_CNT) begin
                  state_nxt_s = ST_FIX;
               end else begin
                  state_nxt_s = ST_CALC;
               end
            end
            ST_FIX:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Operand magnitudes for signed ops
   always_comb begin
      if (signed_s && a_r[W-1]) begin
         mag_a_s = -a_r;
      end else begin
         mag_a_s = a_r;
      end
      if (signed_s && b_r[W-1]) begin
         mag_b_s = -b_r;
      end else begin
         mag_b_s = b_r;
      end
   end

   // Adder operands: divide uses a 33-bit partial remainder (it includes
   // the bit about to be shifted out), multiply adds to the upper half
   always_comb begin
      step_y_s = {1'b0, opnd_r};
      if (div_op_s) begin
         step_x_s = acc_r[2*W-1:W-1];
      end else begin
         step_x_s = {1'b0, acc_r[2*W-1:W]};
      end
   end

   md_step #(.W(W + 1)) u_md_step (
      .x      (step_x_s),
      .y      (step_y_s),
      .sub    (div_op_s),
      .res    (step_res_s),
      .borrow (step_borrow_s)
   );

   // One iteration of shift-add multiply or restoring divide
   always_comb begin
      if (div_op_s) begin
         if (!step_borrow_s) begin
            acc_step_s = {step_res_s[W-1:0], acc_r[W-2:0], 1'b1};
         end else begin
            acc_step_s = {acc_r[2*W-2:0], 1'b0};
         end
      end else begin
         if (acc_r[0]) begin
            acc_step_s = {step_res_s, acc_r[W-1:1]};
         end else begin
            acc_step_s = {1'b0, acc_r[2*W-1:1]};
         end
      end
   end

   // Sign fix and HI/LO selection for the FIX cycle
   always_comb begin
      if (neg_q_r) begin
         prod_s = -acc_r;
         quot_s = -acc_r[W-1:0];
      end else begin
         prod_s = acc_r;
         quot_s = acc_r[W-1:0];
      end
      if (neg_r_r) begin
         rem_s = -acc_r[2*W-1:W];
      end else begin
         rem_s = acc_r[2*W-1:W];
      end
      if (div_op_s) begin
         if (dbz_r) begin
            fix_hi_s = a_r;
            fix_lo_s = {W{1'b1}};
         end else begin
            fix_hi_s = rem_s;
            fix_lo_s = quot_s;
         end
      end else begin
         fix_hi_s = prod_s[2*W-1:W];
         fix_lo_s = prod_s[W-1:0];
      end
   end

   // Datapath, HI/LO and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r    <= MDOP_NONE;
         a_r     <= {W{1'b0}};
         b_r     <= {W{1'b0}};
         opnd_r  <= {W{1'b0}};
         acc_r   <= {(2*W){1'b0}};
         count_r <= {CW{1'b0}};
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         dbz_r   <= 1'b0;
         hi_r    <= {W{1'b0}};
         lo_r    <= {W{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start && !flush) begin
                  if (is_md_op(op)) begin
                     op_r   <= op;
                     a_r    <= a;
                     b_r    <= b;
                     busy_r <= 1'b1;
                  end else if (op == MDOP_MTHI) begin
                     hi_r <= a;
                  end else if (op == MDOP_MTLO) begin
                     lo_r <= a;
                  end
               end
            end
            ST_PREP: begin
               if (flush) begin
                  busy_r <= 1'b0;
               end else begin
                  neg_q_r <= signed_s & (a_r[W-1] ^ b_r[W-1]);
                  neg_r_r <= signed_s & a_r[W-1];
                  count_r <= {CW{1'b0}};
                  if (div_op_s) begin
                     acc_r  <= {{W{1'b0}}, mag_a_s};
                     opnd_r <= mag_b_s;
                     dbz_r  <= (b_r == {W{1'b0}});
                  end else begin
                     acc_r  <= {{W{1'b0}}, mag_b_s};
                     opnd_r <= mag_a_s;
                  end
               end
            end
            ST_CALC: begin
               if (flush) begin
                  busy_r <= 1'b0;
               end else begin
                  acc_r   <= acc_step_s;
                  count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_FIX: begin
               busy_r <= 1'b0;
               if (!flush) begin
                  hi_r   <= fix_hi_s;
                  lo_r   <= fix_lo_s;
                  done_r <= 1'b1;
               end
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign div_by_zero = dbz_r;
   assign hi          = hi_r;
   assign lo          = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        flush;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   // Architectural model state
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;
   logic        exp_dbz = 1'b0;

   mul_div_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Reference: results straight from integer arithmetic
   task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l);
      logic [63:0] p;
      int sx, sy;
      sx = x;
      sy = y;
      h = 32'd0;
      l = 32'd0;
      case (o)
         MDOP_MULT: begin
            p = 64'(longint'(sx) * longint'(sy));
            h = p[63:32]; l = p[31:0];
         end
         MDOP_MULTU: begin
            p = {32'd0, x} * {32'd0, y};
            h = p[63:32]; l = p[31:0];
         end
         MDOP_DIV: begin
            if (y == 32'd0) begin
               h = x; l = 32'hFFFF_FFFF;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               h = 32'd0; l = 32'h8000_0000;
            end else begin
               l = 32'(sx / sy); h = 32'(sx % sy);
            end
         end
         MDOP_DIVU: begin
            if (y == 32'd0) begin
               h = x; l = 32'hFFFF_FFFF;
            end else begin
               l = x / y; h = x % y;
            end
         end
         default: begin
            h = 32'd0; l = 32'd0;
         end
      endcase
   endtask

   // Issue a mult/div at the current negedge; check timing and result.
   // Returns at the negedge of the done cycle (cycle 35).
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string name);
      logic [31:0] eh, el;
      int bad;
      model(o, x, y, eh, el);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; op = MDOP_NONE; a = 32'd0; b = 32'd0;
      bad = 0;
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         if (busy !== (c <= 34)) bad++;
         if (done !== (c == 35)) bad++;
      end
      exp_hi = eh;
      exp_lo = el;
      if (o == MDOP_DIV || o == MDOP_DIVU) exp_dbz = (y == 32'd0);
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s timing: %0d busy/done cycle errors, required 0", name, bad);
      end
      checks++;
      if (hi !== exp_hi) begin
         errors++;
         $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi);
      end
      checks++;
      if (lo !== exp_lo) begin
         errors++;
         $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo);
      end
      checks++;
      if (div_by_zero !== exp_dbz) begin
         errors++;
         $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, exp_dbz);
      end
   endtask

   // mthi/mtlo at the current negedge, optionally with flush asserted
   task automatic move_to(input logic [2:0] o, input logic [31:0] x, input logic fl,
                          input string name);
      start = 1'b1; op = o; a = x; flush = fl;
      @(posedge clk); #1;
      start = 1'b0; op = MDOP_NONE; a = 32'd0; flush = 1'b0;
      if (!fl && o == MDOP_MTHI) exp_hi = x;
      if (!fl && o == MDOP_MTLO) exp_lo = x;
      @(negedge clk);
      checks++;
      if (hi !== exp_hi || lo !== exp_lo) begin
         errors++;
         $display("FAIL %s hi/lo: got %h/%h expected %h/%h", name, hi, lo, exp_hi, exp_lo);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s busy/done: got %b/%b expected 0/0", name, busy, done);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         errors++;
         $display("FAIL reset flags: got %b expected 000", {busy, done, div_by_zero});
      end
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL reset hilo: got %h/%h expected 0/0", hi, lo);
      end
   endtask

   task automatic test_directed();
      run_op(MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      checks++;
      if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         errors++;
         $display("FAIL multu_max const: got %h/%h expected fffffffe/00000001", hi, lo);
      end
      run_op(MDOP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
      run_op(MDOP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minsq");
      run_op(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         errors++;
         $display("FAIL div_neg7by2 const: got %h/%h expected ffffffff/fffffffd", hi, lo);
      end
      run_op(MDOP_DIVU, 32'd100, 32'd7, "divu_100by7");
      run_op(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
   endtask

   task automatic test_div_by_zero();
      run_op(MDOP_DIV, 32'd5, 32'd0, "div_by0");
      run_op(MDOP_DIVU, 32'd9, 32'd3, "divu_after_by0");
      run_op(MDOP_DIVU, 32'h8765_4321, 32'd0, "divu_by0");
      run_op(MDOP_MULT, 32'd11, 32'd13, "mult_keeps_dbz");
   endtask

   task automatic test_flush();
      int bad;
      move_to(MDOP_MTHI, 32'h0000_1234, 1'b0, "mthi");
      move_to(MDOP_MTLO, 32'h0000_5678, 1'b0, "mtlo");
      start = 1'b1; op = MDOP_MULT; a = 32'd3; b = 32'd4;
      @(posedge clk); #1;
      start = 1'b0; op = MDOP_NONE; a = 32'd0; b = 32'd0;
      bad = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy !== (c <= 10)) bad++;
         if (done !== 1'b0) bad++;
         if (c == 5) begin
            start = 1'b1; op = MDOP_MTHI; a = 32'hDEAD_BEEF;
         end
         if (c == 6) begin
            start = 1'b0; op = MDOP_NONE; a = 32'd0;
         end
         if (c == 10) flush = 1'b1;
         if (c == 11) flush = 1'b0;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL flush timing: %0d busy/done cycle errors, required 0", bad);
      end
      checks++;
      if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678) begin
         errors++;
         $display("FAIL flush hilo: got %h/%h expected 00001234/00005678", hi, lo);
      end
      move_to(MDOP_MTHI, 32'hCAFE_0000, 1'b1, "flush_mthi");
      move_to(MDOP_MULT, 32'd5, 1'b1, "flush_mult");
   endtask

   task automatic test_back_to_back();
      run_op(MDOP_MULTU, 32'd1000, 32'd1000, "b2b_first");
      run_op(MDOP_DIVU, 32'd1000, 32'd33, "b2b_second");
   endtask

   task automatic test_async_reset();
      start = 1'b1; op = MDOP_DIVU; a = 32'd1000; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; op = MDOP_NONE; a = 32'd0; b = 32'd0;
      for (int c = 1; c <= 20; c++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_hi = 32'd0; exp_lo = 32'd0; exp_dbz = 1'b0;
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all 0",
                  busy, done, div_by_zero, hi, lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(MDOP_MULT, 32'd2, 32'd3, "mult_after_reset");
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] x, y;
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(1, 6));
         x = $urandom;
         y = $urandom;
         if ($urandom_range(0, 7) == 0) y = 32'd0;
         if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(8, 31);
         if (o == MDOP_DIV && $urandom_range(0, 9) == 0) begin
            x = 32'h8000_0000; y = 32'hFFFF_FFFF;
         end
         if (o == MDOP_MTHI || o == MDOP_MTLO) move_to(o, x, 1'b0, "rand_move");
         else run_op(o, x, y, "rand_op");
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = MDOP_NONE; a = 32'd0; b = 32'd0; flush = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_directed();
      test_div_by_zero();
      test_flush();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
